// File: rtl/bram_arbiter_pkg.sv
// bram_arbiter_pkg: shared state encoding and widths for the BRAM arbiter
package bram_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam int NREQ = 3;
    localparam int AW = 15;
    localparam int DW = 32;
endpackage

// File: rtl/bram_arbiter_rr_picker.sv
// rr_picker: round-robin search for the first set request after last_grant
module rr_picker #(
    parameter int N = 3,
    parameter int GW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] last_grant,
    output logic [GW-1:0] grant,
    output logic          valid
);
    int k;
    // scan from the farthest candidate down so the nearest one after last_grant wins
    always_comb begin
        k = 0;
        grant = '0;
        valid = 1'b0;
        for (int i = N; i >= 1; i--) begin
            k = (int'(last_grant) + i) % N;
            if (req[k[GW-1:0]]) begin
                grant = k[GW-1:0];
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bram_arbiter.sv
// bram_arbiter: round-robin arbitration of three requesters onto one BRAM port with timeout
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int NREQ = bram_arbiter_pkg::NREQ
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] we,
    input  logic [AW-1:0]   addr0,
    input  logic [AW-1:0]   addr1,
    input  logic [AW-1:0]   addr2,
    input  logic [DW-1:0]   din0,
    input  logic [DW-1:0]   din1,
    input  logic [DW-1:0]   din2,
    output logic [NREQ-1:0] rdy,
    output logic            err,
    output logic [DW-1:0]   dout,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_din,
    output logic            mem_we,
    output logic            mem_start_read,
    input  logic [DW-1:0]   mem_dout,
    input  logic            mem_read_rdy,
    input  logic            mem_save_rdy
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t          state_q, state_d;
    logic [GW-1:0]   last_q, last_d;
    logic            we_q, we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   din_q, din_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [NREQ-1:0] rdy_q, rdy_d;
    logic            err_q, err_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic [GW-1:0]   pick;
    logic            pick_valid;
    logic            done;

    // a requester still holds req in its rdy cycle, so it is masked to avoid a repeat grant
    rr_picker #(.N(NREQ), .GW(GW)) u_picker (
        .req       (req & ~rdy_q),
        .last_grant(last_q),
        .grant     (pick),
        .valid     (pick_valid)
    );

    // next-state, latching of the granted port and completion/timeout handling
    always_comb begin
        state_d = state_q;
        last_d = last_q;
        we_d = we_q;
        addr_d = addr_q;
        din_d = din_q;
        cnt_d = cnt_q;
        rdy_d = '0;
        err_d = 1'b0;
        dout_d = dout_q;
        done = 1'b0;
        case (state_q)
            IDLE: if (pick_valid) begin
                state_d = ISSUE;
                last_d = pick;
                we_d = we[pick];
                addr_d = (pick == GW'(0)) ? addr0 : (pick == GW'(1)) ? addr1 : addr2;
                din_d = (pick == GW'(0)) ? din0 : (pick == GW'(1)) ? din1 : din2;
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + 4'd1;
                done = we_q ? mem_save_rdy : mem_read_rdy;
                if (done || cnt_d == 4'(TIMEOUT)) begin
                    state_d = IDLE;
                    rdy_d[last_q] = 1'b1;
                    err_d = !done;
                    dout_d = (done && !we_q) ? mem_dout : dout_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q <= GW'(NREQ - 1);
            we_q <= 1'b0;
            addr_q <= '0;
            din_q <= '0;
            cnt_q <= '0;
            rdy_q <= '0;
            err_q <= 1'b0;
            dout_q <= '0;
        end else begin
            state_q <= state_d;
            last_q <= last_d;
            we_q <= we_d;
            addr_q <= addr_d;
            din_q <= din_d;
            cnt_q <= cnt_d;
            rdy_q <= rdy_d;
            err_q <= err_d;
            dout_q <= dout_d;
        end
    end

    assign rdy = rdy_q;
    assign err = err_q;
    assign dout = dout_q;
    assign mem_addr = addr_q;
    assign mem_din = din_q;
    assign mem_we = (state_q == ISSUE) && we_q;
    assign mem_start_read = (state_q == ISSUE) && !we_q;
endmodule

// File: tb/tb_bram_arbiter.sv
// tb_bram_arbiter: directed checks of arbitration, BRAM handshakes, timeout and reset
module tb_bram_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req, we, rdy;
    logic [14:0] addr0, addr1, addr2, mem_addr;
    logic [31:0] din0, din1, din2, dout, mem_din, mem_dout;
    logic        err, mem_we, mem_start_read, mem_read_rdy, mem_save_rdy;
    int compared = 0;
    int mismatched = 0;

    bram_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .addr2(addr2),
        .din0(din0), .din1(din1), .din2(din2),
        .rdy(rdy), .err(err), .dout(dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
        .mem_start_read(mem_start_read), .mem_dout(mem_dout),
        .mem_read_rdy(mem_read_rdy), .mem_save_rdy(mem_save_rdy)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; we = '0;
        addr0 = '0; addr1 = '0; addr2 = '0;
        din0 = '0; din1 = '0; din2 = '0;
        mem_dout = '0; mem_read_rdy = 1'b0; mem_save_rdy = 1'b0;
        step(2);
        chk("rst_rdy", 32'(rdy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_dout", dout, 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_din", mem_din, 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_start", 32'(mem_start_read), 32'h0);
        // single read on port 0
        rst = 1'b0; req = 3'b001; addr0 = 15'h0123;
        step(1);
        chk("rd_start", 32'(mem_start_read), 32'h1);
        chk("rd_we", 32'(mem_we), 32'h0);
        chk("rd_addr", 32'(mem_addr), 32'h0123);
        step(1);
        chk("rd_start_off", 32'(mem_start_read), 32'h0);
        chk("rd_addr_hold", 32'(mem_addr), 32'h0123);
        step(1);
        mem_read_rdy = 1'b1; mem_dout = 32'hDEADBEEF;
        step(1);
        mem_read_rdy = 1'b0;
        chk("rd_rdy", 32'(rdy), 32'h1);
        chk("rd_err", 32'(err), 32'h0);
        chk("rd_dout", dout, 32'hDEADBEEF);
        step(1);
        chk("rd_no_regrant", 32'(mem_start_read), 32'h0);
        chk("rd_rdy_pulse", 32'(rdy), 32'h0);
        // port 1 write at top address, wrong-type completion ignored
        req = 3'b010; we = 3'b010; addr1 = 15'h7FFF; din1 = 32'h55;
        step(1);
        chk("wr_we", 32'(mem_we), 32'h1);
        chk("wr_start", 32'(mem_start_read), 32'h0);
        chk("wr_addr", 32'(mem_addr), 32'h7FFF);
        chk("wr_din", mem_din, 32'h55);
        step(1);
        chk("wr_we_once", 32'(mem_we), 32'h0);
        chk("wr_addr_hold", 32'(mem_addr), 32'h7FFF);
        mem_read_rdy = 1'b1;
        step(1);
        chk("wr_wrong_type", 32'(rdy), 32'h0);
        mem_read_rdy = 1'b0; mem_save_rdy = 1'b1;
        step(1);
        mem_save_rdy = 1'b0;
        chk("wr_rdy", 32'(rdy), 32'h2);
        chk("wr_err", 32'(err), 32'h0);
        chk("wr_dout_kept", dout, 32'hDEADBEEF);
        req = '0; we = '0; mem_read_rdy = 1'b1;
        step(1);
        mem_read_rdy = 1'b0;
        chk("idle_ignore", 32'(rdy), 32'h0);
        // all ports requesting from reset: strict rotation 0,1,2,0,1,2
        rst = 1'b1;
        step(1);
        chk("rst_dout_clr", dout, 32'h0);
        addr0 = 15'h10; addr1 = 15'h11; addr2 = 15'h12;
        rst = 1'b0; req = 3'b111;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("rr_start", 32'(mem_start_read), 32'h1);
            chk("rr_addr", 32'(mem_addr), 32'h10 + 32'(i % 3));
            step(1);
            mem_read_rdy = 1'b1; mem_dout = 32'hA0 + 32'(i);
            step(1);
            mem_read_rdy = 1'b0;
            chk("rr_rdy", 32'(rdy), 32'(1 << (i % 3)));
            chk("rr_dout", dout, 32'hA0 + 32'(i));
            if (i == 5) req = 3'b001;
        end
        // no completion: timeout after 15 WAIT cycles
        step(1);
        chk("to_start", 32'(mem_start_read), 32'h1);
        chk("to_addr", 32'(mem_addr), 32'h10);
        step(15);
        chk("to_not_early", 32'(rdy), 32'h0);
        step(1);
        chk("to_rdy", 32'(rdy), 32'h1);
        chk("to_err", 32'(err), 32'h1);
        chk("to_dout_kept", dout, 32'hA5);
        req = 3'b100;
        // completion on the timeout cycle wins
        step(1);
        chk("tie_start", 32'(mem_start_read), 32'h1);
        chk("tie_addr", 32'(mem_addr), 32'h12);
        step(15);
        chk("tie_not_early", 32'(rdy), 32'h0);
        mem_read_rdy = 1'b1; mem_dout = 32'hCAFEF00D;
        step(1);
        mem_read_rdy = 1'b0;
        chk("tie_rdy", 32'(rdy), 32'h4);
        chk("tie_err", 32'(err), 32'h0);
        chk("tie_dout", dout, 32'hCAFEF00D);
        req = '0;
        // reset during WAIT, late completion ignored
        step(1);
        req = 3'b001;
        step(2);
        rst = 1'b1;
        #1;
        chk("arst_addr", 32'(mem_addr), 32'h0);
        chk("arst_dout", dout, 32'h0);
        req = '0;
        step(1);
        rst = 1'b0;
        step(1);
        mem_read_rdy = 1'b1;
        step(1);
        mem_read_rdy = 1'b0;
        chk("late_rdy", 32'(rdy), 32'h0);
        chk("late_err", 32'(err), 32'h0);
        chk("late_dout", dout, 32'h0);
        chk("late_start", 32'(mem_start_read), 32'h0);
        chk("late_we", 32'(mem_we), 32'h0);
        req = 3'b010;
        step(1);
        chk("post_rst_start", 32'(mem_start_read), 32'h1);
        chk("post_rst_addr", 32'(mem_addr), 32'h11);
        req = '0;
        step(1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
